vc_lru_tracker: RTL and testbench
=================================

// Module: vc_lru_tracker
// PURPOSE
//  Parametrised true-LRU stack for the victim cache (and any N-way array).
//  Holds the recency order of WAYS ways in a register and supports
//  touch (promote to MRU), demote (push to LRU) and allocate (take the LRU
//  victim and promote it). Sits beside the VC tag/data arrays; the VC
//  controller drives one op per cycle and reads victim_way combinationally.
// PARAMETERS
//  WAYS   8                number of ways tracked (>=2, need not be 2^n)
//  IDX_W  $clog2(WAYS)     width of a way index
// PORTS
//  clk           in   1             clock
//  reset         in   1             synchronous, active-high reset
//  touch_valid   in   1             promote touch_way to MRU
//  touch_way     in   IDX_W         way hit
//  demote_valid  in   1             move demote_way to LRU slot (invalidate)
//  demote_way    in   IDX_W         way invalidated
//  alloc_valid   in   1             consume current victim, promote it to MRU
//  pin_mask      in   WAYS          ways excluded from victim choice (VC_LRU_PIN_EN only)
//  victim_way    out  IDX_W         least-recent eligible way (combinational)
//  victim_valid  out  1             an eligible victim exists
//  alloc_done    out  1             registered 1-cycle pulse, alloc accepted
//  alloc_way     out  IDX_W         registered way granted by last alloc
//  op_drop       out  1             registered pulse, a requested op was ignored
//  lru_state     out  WAYS*IDX_W    stack; slot k = bits[k*IDX_W +: IDX_W]
// BEHAVIOUR
//  - Slot 0 (LSBs) = LRU, slot WAYS-1 (MSBs) = MRU. Every way appears once.
//  - Reset: slot k holds k (LRU=way 0, MRU=way WAYS-1); WAYS=8 -> 24'hFAC688.
//    alloc_done=0, alloc_way=0, op_drop=0. Reset wins over any op.
//  - Promote(w): find slot j holding w; slots j+1..WAYS-1 shift down one,
//    w written to slot WAYS-1; slots below j unchanged. w already MRU -> no change.
//  - Demote(w): slot j holding w; slots 0..j-1 shift up one, w to slot 0.
//  - One op per edge; priority alloc > touch > demote. Lower-priority
//    requests in the same cycle are discarded and op_drop pulses next cycle.
//  - alloc_valid with victim_valid=1: promote victim_way; next cycle
//    alloc_done=1, alloc_way=that way. With victim_valid=0: no state change,
//    alloc_done=0, op_drop=1; touch/demote in that cycle still discarded.
//  - touch_way/demote_way >= WAYS: op ignored, state unchanged, op_drop=1.
//  - Latency: all state changes visible on lru_state/victim_* the cycle after
//    the request edge. victim_* is a pure function of lru_state (+pin_mask).
//  - alloc_done, op_drop are single-cycle pulses; alloc_way holds until next alloc.
//  - Reset asserted mid-sequence: state returns to reset order next edge, pending
//    pulses cleared.
// CONFIGURATION
//  VC_LRU_PIN_EN defined: victim_way = way in lowest slot whose pin_mask bit
//    is 0; victim_valid=0 when all ways pinned. Touch/demote ignore pins.
//  Undefined: pin_mask unused; victim_way = slot 0; victim_valid tied 1.
// TESTING (WAYS=8)
//  1 reset -> lru_state=24'hFAC688, victim_way=0, alloc_done=0, op_drop=0
//  2 reset; touch 0 -> lru_state=24'h1F58D1, victim_way=1
//  3 reset; touch 7 -> lru_state stays 24'hFAC688, op_drop=0
//  4 reset; demote 7 -> lru_state=24'hD63447, victim_way=7
//  5 reset; alloc+touch 3 same cycle -> alloc_done=1, alloc_way=0,
//    op_drop=1, lru_state=24'h1F58D1
//  6 PIN_EN: reset; pin_mask=8'h01 -> victim_way=1; alloc -> alloc_way=1;
//    pin_mask=8'hFF -> victim_valid=0, alloc -> alloc_done=0, op_drop=1

Source files
------------

// File: rtl/vc_lru_tracker.sv
// True-LRU recency stack for WAYS ways: touch (promote to MRU), demote (push to LRU), allocate.
// Define VC_LRU_PIN_EN to let pin_mask exclude ways from victim selection.
module vc_lru_tracker #(
  parameter int WAYS  = 8,
  parameter int IDX_W = $clog2(WAYS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  touch_valid,
  input  logic [IDX_W-1:0]      touch_way,
  input  logic                  demote_valid,
  input  logic [IDX_W-1:0]      demote_way,
  input  logic                  alloc_valid,
  input  logic [WAYS-1:0]       pin_mask,
  output logic [IDX_W-1:0]      victim_way,
  output logic                  victim_valid,
  output logic                  alloc_done,
  output logic [IDX_W-1:0]      alloc_way,
  output logic                  op_drop,
  output logic [WAYS*IDX_W-1:0] lru_state
);

  typedef logic [WAYS-1:0][IDX_W-1:0] stack_t;

  localparam logic [IDX_W:0] NumWays = (IDX_W+1)'(WAYS);

  stack_t           stack_q, stack_d;
  logic             alloc_done_q, alloc_done_d;
  logic [IDX_W-1:0] alloc_way_q, alloc_way_d;
  logic             op_drop_q, op_drop_d;

  function automatic stack_t reset_stack();
    stack_t r;
    for (int k = 0; k < WAYS; k++) r[k] = IDX_W'(k);
    return r;
  endfunction

  // Slots above the hit slide down one place; the hit way lands in the MRU slot.
  function automatic stack_t promote(stack_t s, logic [IDX_W-1:0] w);
    stack_t r;
    int     j;
    j = 0;
    for (int k = 0; k < WAYS; k++) if (s[k] == w) j = k;
    r = s;
    for (int k = 0; k < WAYS-1; k++) if (k >= j) r[k] = s[k+1];
    r[WAYS-1] = w;
    return r;
  endfunction

  function automatic stack_t demote(stack_t s, logic [IDX_W-1:0] w);
    stack_t r;
    int     j;
    j = 0;
    for (int k = 0; k < WAYS; k++) if (s[k] == w) j = k;
    r = s;
    for (int k = 1; k < WAYS; k++) if (k <= j) r[k] = s[k-1];
    r[0] = w;
    return r;
  endfunction

`ifdef VC_LRU_PIN_EN
  // Scan from MRU down so the lowest unpinned slot is the one that sticks.
  always_comb begin
    victim_way   = '0;
    victim_valid = 1'b0;
    for (int k = WAYS-1; k >= 0; k--) begin
      if (!pin_mask[stack_q[k]]) begin
        victim_way   = stack_q[k];
        victim_valid = 1'b1;
      end
    end
  end
`else
  logic unused_pin_mask;
  assign unused_pin_mask = ^pin_mask;
  assign victim_way      = stack_q[0];
  assign victim_valid    = 1'b1;
`endif

  always_comb begin
    stack_d      = stack_q;
    alloc_done_d = 1'b0;
    alloc_way_d  = alloc_way_q;
    op_drop_d    = 1'b0;
    if (alloc_valid) begin
      op_drop_d = touch_valid | demote_valid;
      if (victim_valid) begin
        stack_d      = promote(stack_q, victim_way);
        alloc_done_d = 1'b1;
        alloc_way_d  = victim_way;
      end else begin
        op_drop_d = 1'b1;
      end
    end else if (touch_valid) begin
      op_drop_d = demote_valid;
      if ({1'b0, touch_way} >= NumWays) op_drop_d = 1'b1;
      else stack_d = promote(stack_q, touch_way);
    end else if (demote_valid) begin
      if ({1'b0, demote_way} >= NumWays) op_drop_d = 1'b1;
      else stack_d = demote(stack_q, demote_way);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stack_q      <= reset_stack();
      alloc_done_q <= 1'b0;
      alloc_way_q  <= '0;
      op_drop_q    <= 1'b0;
    end else begin
      stack_q      <= stack_d;
      alloc_done_q <= alloc_done_d;
      alloc_way_q  <= alloc_way_d;
      op_drop_q    <= op_drop_d;
    end
  end

  assign lru_state  = stack_q;
  assign alloc_done = alloc_done_q;
  assign alloc_way  = alloc_way_q;
  assign op_drop    = op_drop_q;

endmodule

// File: tb/tb_vc_lru_tracker.sv
// Directed bench for vc_lru_tracker (WAYS=8) with hand-computed stack images.
module tb_vc_lru_tracker;

  logic        clk = 1'b0;
  logic        reset;
  logic        touchValid, demoteValid, allocValid;
  logic [2:0]  touchWay, demoteWay;
  logic [7:0]  pinMask;
  logic [2:0]  victimWay;
  logic        victimValid, allocDone, opDrop;
  logic [2:0]  allocWay;
  logic [23:0] lruState;

  int total = 0;
  int bad   = 0;

  vc_lru_tracker #(.WAYS(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .touch_valid  (touchValid),
    .touch_way    (touchWay),
    .demote_valid (demoteValid),
    .demote_way   (demoteWay),
    .alloc_valid  (allocValid),
    .pin_mask     (pinMask),
    .victim_way   (victimWay),
    .victim_valid (victimValid),
    .alloc_done   (allocDone),
    .alloc_way    (allocWay),
    .op_drop      (opDrop),
    .lru_state    (lruState)
  );

  always #5 clk = ~clk;

  // Drive one cycle of requests, then sample 1 time unit after the edge.
  task automatic applyStimulus(input logic rst, input logic al,
                               input logic tv, input logic [2:0] tw,
                               input logic dv, input logic [2:0] dw);
    reset       = rst;
    allocValid  = al;
    touchValid  = tv;
    touchWay    = tw;
    demoteValid = dv;
    demoteWay   = dw;
    @(posedge clk);
    #1;
    reset       = 1'b0;
    allocValid  = 1'b0;
    touchValid  = 1'b0;
    demoteValid = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
  endtask

  initial begin
    pinMask = 8'h00;
    applyStimulus(1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 3'd0);
    doReset();
    $display("[TB] reset state");
    checkOutput("rst_lru", lruState, 24'hFAC688);
    checkOutput("rst_victim", victimWay, 3'd0);
    checkOutput("rst_vvalid", victimValid, 1'b1);
    checkOutput("rst_done", allocDone, 1'b0);
    checkOutput("rst_drop", opDrop, 1'b0);
    checkOutput("rst_away", allocWay, 3'd0);

    $display("[TB] touch LRU way 0");
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 3'd0);
    checkOutput("t0_lru", lruState, 24'h1F58D1);
    checkOutput("t0_victim", victimWay, 3'd1);
    checkOutput("t0_drop", opDrop, 1'b0);

    $display("[TB] touch MRU way 7");
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd7, 1'b0, 3'd0);
    checkOutput("t7_lru", lruState, 24'hFAC688);
    checkOutput("t7_drop", opDrop, 1'b0);

    $display("[TB] demote MRU way 7");
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 3'd7);
    checkOutput("d7_lru", lruState, 24'hD63447);
    checkOutput("d7_victim", victimWay, 3'd7);

    $display("[TB] demote LRU way 0");
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 3'd0);
    checkOutput("d0_lru", lruState, 24'hFAC688);

    $display("[TB] touch 3 then demote 3");
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 3'd0);
    checkOutput("t3_lru", lruState, 24'h7F5888);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 3'd3);
    checkOutput("d3_lru", lruState, 24'hFAC443);
    checkOutput("d3_victim", victimWay, 3'd3);

    $display("[TB] touch and demote together");
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd5, 1'b1, 3'd2);
    checkOutput("td_lru", lruState, 24'hBF4688);
    checkOutput("td_drop", opDrop, 1'b1);
    idle();
    checkOutput("td_drop_clr", opDrop, 1'b0);

    $display("[TB] alloc with touch, then second alloc");
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 3'd0);
    checkOutput("a0_done", allocDone, 1'b1);
    checkOutput("a0_way", allocWay, 3'd0);
    checkOutput("a0_drop", opDrop, 1'b1);
    checkOutput("a0_lru", lruState, 24'h1F58D1);
    idle();
    checkOutput("a0_done_clr", allocDone, 1'b0);
    checkOutput("a0_drop_clr", opDrop, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0);
    checkOutput("a1_done", allocDone, 1'b1);
    checkOutput("a1_way", allocWay, 3'd1);
    checkOutput("a1_drop", opDrop, 1'b0);
    checkOutput("a1_lru", lruState, 24'h23EB1A);
    idle();
    checkOutput("a1_way_hold", allocWay, 3'd1);
    checkOutput("a1_done_clr", allocDone, 1'b0);

    $display("[TB] reset beats pending ops");
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd4, 1'b0, 3'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 3'd4, 1'b1, 3'd2);
    checkOutput("mr_lru", lruState, 24'hFAC688);
    checkOutput("mr_done", allocDone, 1'b0);
    checkOutput("mr_drop", opDrop, 1'b0);
    checkOutput("mr_away", allocWay, 3'd0);

`ifdef VC_LRU_PIN_EN
    $display("[TB] pinned victim selection");
    doReset();
    pinMask = 8'h01;
    #1;
    checkOutput("pin_victim", victimWay, 3'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0);
    checkOutput("pin_done", allocDone, 1'b1);
    checkOutput("pin_away", allocWay, 3'd1);
    checkOutput("pin_lru", lruState, 24'h3F58D0);
    pinMask = 8'hFF;
    #1;
    checkOutput("pinall_vvalid", victimValid, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0);
    checkOutput("pinall_done", allocDone, 1'b0);
    checkOutput("pinall_drop", opDrop, 1'b1);
    checkOutput("pinall_lru", lruState, 24'h3F58D0);
    pinMask = 8'h00;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
